// File: rtl/raptor64_branch_resolver.sv
// raptor64_branch_resolver
//   Carries the IF-stage branch prediction through the RF and EX pipeline
//   slots and compares it with the resolved outcome at EX. A wrong
//   prediction produces a registered one-cycle mispredict pulse, the
//   corrected fetch address, and squashes the wrong-path slots.
//   Optional statistics counters are built when RAPTOR64_BR_STATS_EN is
//   defined; otherwise stat_branches/stat_miss are tied to zero.
module raptor64_branch_resolver #(
  parameter int AMSB = 63
) (
  input  logic          clk,
  input  logic          rst,          // asynchronous, active-low
  input  logic          advanceI,
  input  logic          advanceR,
  input  logic          advanceX,
  input  logic          flush,
  input  logic          ipredict,
  input  logic          xIsBranch,
  input  logic          takb,
  input  logic [AMSB:0] xpc,
  input  logic [AMSB:0] xtarget,
  output logic          xpredicted,
  output logic          mispredict,
  output logic [AMSB:0] redirect_pc,
  output logic [31:0]   stat_branches,
  output logic [31:0]   stat_miss
);

  localparam logic [AMSB:0] PC_STEP = 4;

  // Prediction slots travelling with the RF and EX instructions.
  logic          r_rf_pred;
  logic          r_rf_v;
  logic          r_ex_pred;
  logic          r_ex_v;
  logic          r_mispredict;
  logic [AMSB:0] r_redirect_pc;

  logic          w_res;
  logic          w_miss;
  logic [AMSB:0] w_fix_pc;

  // An empty EX slot reads as "predicted not-taken".
  assign xpredicted = r_ex_pred & r_ex_v;

  // A flush on the same edge suppresses resolution entirely.
  assign w_res    = advanceX & xIsBranch & ~flush;
  assign w_miss   = w_res & (xpredicted != takb);
  // Fall-through address wraps modulo 2^(AMSB+1).
  assign w_fix_pc = takb ? xtarget : (xpc + PC_STEP);

  // Slot update: flush beats mispredict squash, which beats normal advance.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values, independent of statement order inside the block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rf_pred <= 1'b0;
      r_rf_v    <= 1'b0;
      r_ex_pred <= 1'b0;
      r_ex_v    <= 1'b0;
    end else if (flush || w_miss) begin
      r_rf_v <= 1'b0;
      r_ex_v <= 1'b0;
    end else begin
      if (advanceR) begin
        r_ex_pred <= r_rf_pred;
        r_ex_v    <= r_rf_v;
      end else if (advanceX) begin
        r_ex_v <= 1'b0;
      end
      if (advanceI) begin
        r_rf_pred <= ipredict;
        r_rf_v    <= 1'b1;
      end else if (advanceR) begin
        r_rf_v <= 1'b0;
      end
    end
  end

  // Registered redirect: one-cycle pulse, address held until the next miss.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mispredict  <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      r_mispredict <= w_miss;
      if (w_miss) begin
        r_redirect_pc <= w_fix_pc;
      end
    end
  end

  assign mispredict  = r_mispredict;
  assign redirect_pc = r_redirect_pc;

`ifdef RAPTOR64_BR_STATS_EN
  logic [31:0] r_stat_branches;
  logic [31:0] r_stat_miss;

  // Saturating resolved-branch and mispredict counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat_branches <= '0;
      r_stat_miss     <= '0;
    end else begin
      if (w_res && (r_stat_branches != 32'hFFFF_FFFF)) begin
        r_stat_branches <= r_stat_branches + 32'd1;
      end
      if (w_miss && (r_stat_miss != 32'hFFFF_FFFF)) begin
        r_stat_miss <= r_stat_miss + 32'd1;
      end
    end
  end

  assign stat_branches = r_stat_branches;
  assign stat_miss     = r_stat_miss;
`else
  assign stat_branches = 32'd0;
  assign stat_miss     = 32'd0;
`endif

endmodule

// File: tb/tb_raptor64_branch_resolver.sv
// Directed testbench for raptor64_branch_resolver (AMSB = 63).
// Inputs change 1 time unit after the rising edge; outputs are checked there.
module tb_raptor64_branch_resolver;

  localparam int AMSB = 63;

  logic          clk;
  logic          rst;
  logic          advanceI;
  logic          advanceR;
  logic          advanceX;
  logic          flush;
  logic          ipredict;
  logic          xIsBranch;
  logic          takb;
  logic [AMSB:0] xpc;
  logic [AMSB:0] xtarget;
  logic          xpredicted;
  logic          mispredict;
  logic [AMSB:0] redirect_pc;
  logic [31:0]   stat_branches;
  logic [31:0]   stat_miss;

  int vectors;
  int miscompares;

  raptor64_branch_resolver #(.AMSB(AMSB)) dut (
    .clk          (clk),
    .rst          (rst),
    .advanceI     (advanceI),
    .advanceR     (advanceR),
    .advanceX     (advanceX),
    .flush        (flush),
    .ipredict     (ipredict),
    .xIsBranch    (xIsBranch),
    .takb         (takb),
    .xpc          (xpc),
    .xtarget      (xtarget),
    .xpredicted   (xpredicted),
    .mispredict   (mispredict),
    .redirect_pc  (redirect_pc),
    .stat_branches(stat_branches),
    .stat_miss    (stat_miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected counter value: real count with statistics built, else zero.
  function automatic logic [31:0] st(input int n);
`ifdef RAPTOR64_BR_STATS_EN
    return 32'(n);
`else
    if (n < 0) return 32'd1;
    return 32'd0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    advanceI  = 1'b0;
    advanceR  = 1'b0;
    advanceX  = 1'b0;
    flush     = 1'b0;
    ipredict  = 1'b0;
    xIsBranch = 1'b0;
    takb      = 1'b0;
  endtask

  // Move one instruction with prediction p from IF through RF into EX.
  task automatic load(input logic p);
    idle();
    advanceI = 1'b1;
    ipredict = p;
    tick();
    idle();
    advanceR = 1'b1;
    tick();
    idle();
  endtask

  // Set up a resolving branch in EX for the next edge.
  task automatic resolve(input logic t, input logic [63:0] pc, input logic [63:0] tgt);
    advanceX  = 1'b1;
    xIsBranch = 1'b1;
    takb      = t;
    xpc       = pc;
    xtarget   = tgt;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    idle();
    xpc     = '0;
    xtarget = '0;
    rst     = 1'b0;

    // Reset state
    #12;
    check("rst_mispredict", {63'd0, mispredict}, 64'd0);
    check("rst_redirect",   redirect_pc, 64'd0);
    check("rst_xpredicted", {63'd0, xpredicted}, 64'd0);
    check("rst_stat_br",    {32'd0, stat_branches}, {32'd0, st(0)});
    check("rst_stat_miss",  {32'd0, stat_miss}, {32'd0, st(0)});
    rst = 1'b1;
    tick();

    // Correct taken prediction
    load(1'b1);
    check("ok_xpredicted", {63'd0, xpredicted}, 64'd1);
    resolve(1'b1, 64'h100, 64'h2000);
    tick();
    idle();
    check("ok_mispredict", {63'd0, mispredict}, 64'd0);
    check("ok_redirect",   redirect_pc, 64'd0);
    check("ok_bubble",     {63'd0, xpredicted}, 64'd0);
    check("ok_stat_br",    {32'd0, stat_branches}, {32'd0, st(1)});
    check("ok_stat_miss",  {32'd0, stat_miss}, {32'd0, st(0)});

    // Taken miss; a coincident IF->RF instruction must be discarded
    load(1'b0);
    check("tm_xpredicted", {63'd0, xpredicted}, 64'd0);
    resolve(1'b1, 64'h200, 64'h1000);
    advanceI = 1'b1;
    ipredict = 1'b1;
    tick();
    idle();
    check("tm_pulse",      {63'd0, mispredict}, 64'd1);
    check("tm_redirect",   redirect_pc, 64'h1000);
    check("tm_stat_br",    {32'd0, stat_branches}, {32'd0, st(2)});
    check("tm_stat_miss",  {32'd0, stat_miss}, {32'd0, st(1)});
    advanceR = 1'b1;
    tick();
    idle();
    check("tm_pulse_end",  {63'd0, mispredict}, 64'd0);
    check("tm_rf_squash",  {63'd0, xpredicted}, 64'd0);
    check("tm_redir_hold", redirect_pc, 64'h1000);

    // Not-taken miss with fall-through wrap to zero
    load(1'b1);
    resolve(1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h5555);
    tick();
    idle();
    check("wr_pulse",      {63'd0, mispredict}, 64'd1);
    check("wr_redirect",   redirect_pc, 64'd0);
    tick();
    check("wr_pulse_end",  {63'd0, mispredict}, 64'd0);
    check("wr_stat_miss",  {32'd0, stat_miss}, {32'd0, st(2)});

    // Stall: advanceX without advanceR bubbles EX
    load(1'b1);
    advanceX = 1'b1;
    repeat (3) tick();
    idle();
    check("st_xpredicted", {63'd0, xpredicted}, 64'd0);
    resolve(1'b0, 64'h300, 64'h3000);
    tick();
    check("st_nt_ok",      {63'd0, mispredict}, 64'd0);
    resolve(1'b1, 64'h300, 64'h3000);
    tick();
    check("st_t_pulse",    {63'd0, mispredict}, 64'd1);
    check("st_t_redirect", redirect_pc, 64'h3000);
    // Back-to-back miss on the very next edge
    resolve(1'b1, 64'h310, 64'h3100);
    tick();
    idle();
    check("b2b_pulse",     {63'd0, mispredict}, 64'd1);
    check("b2b_redirect",  redirect_pc, 64'h3100);
    tick();
    check("b2b_end",       {63'd0, mispredict}, 64'd0);
    check("b2b_stat_br",   {32'd0, stat_branches}, {32'd0, st(6)});
    check("b2b_stat_miss", {32'd0, stat_miss}, {32'd0, st(4)});

    // Flush coincident with a mispredicting branch
    load(1'b1);
    advanceI = 1'b1;
    ipredict = 1'b1;
    tick();
    idle();
    resolve(1'b0, 64'h400, 64'h4000);
    flush = 1'b1;
    tick();
    idle();
    check("fl_no_pulse",   {63'd0, mispredict}, 64'd0);
    check("fl_redir_hold", redirect_pc, 64'h3100);
    check("fl_ex_clear",   {63'd0, xpredicted}, 64'd0);
    check("fl_stat_br",    {32'd0, stat_branches}, {32'd0, st(6)});
    check("fl_stat_miss",  {32'd0, stat_miss}, {32'd0, st(4)});
    advanceR = 1'b1;
    tick();
    idle();
    check("fl_rf_clear",   {63'd0, xpredicted}, 64'd1 & 64'd0);

    // Async reset in the middle of a pending pulse
    load(1'b0);
    resolve(1'b1, 64'h500, 64'h6000);
    tick();
    idle();
    check("ar_pulse",      {63'd0, mispredict}, 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("ar_immediate",  {63'd0, mispredict}, 64'd0);
    check("ar_redirect",   redirect_pc, 64'd0);
    check("ar_stat_br",    {32'd0, stat_branches}, {32'd0, st(0)});
    check("ar_stat_miss",  {32'd0, stat_miss}, {32'd0, st(0)});
    tick();
    rst = 1'b1;
    tick();
    check("ar_no_pulse",   {63'd0, mispredict}, 64'd0);
    // First resolution after release: empty EX, taken -> miss
    resolve(1'b1, 64'h600, 64'h7000);
    tick();
    idle();
    check("ar_first_res",  {63'd0, mispredict}, 64'd1);
    check("ar_first_pc",   redirect_pc, 64'h7000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
